// File: rtl/cpu_test_pkg.sv
// cpu_test_pkg
//   Shared types and defaults for the CPU test sequencer slice.
//   - seq_state_t : sequencer state encoding
//   - REG_IDX_W   : RISC-V architectural register index width
//   - DEF_*       : default parameter values used by the top and table
package cpu_test_pkg;

    localparam int REG_IDX_W       = 5;
    localparam int DEF_XLEN        = 32;
    localparam int DEF_IMEM_DEPTH  = 64;
    localparam int DEF_NUM_CHECKS  = 8;
    localparam int DEF_CYC_W       = 16;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/cpu_check_table.sv
// cpu_check_table
//   Expected-register table: NUM_CHECKS entries of {en, reg, value}.
//   Ports:
//     clk, rst              : clock, async active-high reset (clears en bits only)
//     we/widx/wen/wreg/wval : synchronous write port
//     ridx                  : read index
//     ren/rreg/rval         : asynchronous read data for entry ridx
import cpu_test_pkg::*;

module cpu_check_table #(
    parameter int XLEN       = DEF_XLEN,
    parameter int NUM_CHECKS = DEF_NUM_CHECKS,
    localparam int IDX_W     = $clog2(NUM_CHECKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [IDX_W-1:0]     widx,
    input  logic                 wen,
    input  logic [REG_IDX_W-1:0] wreg,
    input  logic [XLEN-1:0]      wval,
    input  logic [IDX_W-1:0]     ridx,
    output logic                 ren,
    output logic [REG_IDX_W-1:0] rreg,
    output logic [XLEN-1:0]      rval
);

    logic [NUM_CHECKS-1:0]                en_q;
    logic [NUM_CHECKS-1:0][REG_IDX_W-1:0] reg_q;
    logic [NUM_CHECKS-1:0][XLEN-1:0]      val_q;

    // Only the valid bits need a reset; stale reg/value data is harmless
    // while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q <= '0;
        end else if (we) begin
            en_q[widx] <= wen;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            reg_q[widx] <= wreg;
            val_q[widx] <= wval;
        end
    end

    assign ren  = en_q[ridx];
    assign rreg = reg_q[ridx];
    assign rval = val_q[ridx];

endmodule

// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer
//   On-chip load-run-check harness for the RISC-V core.
//   LOAD  : stream program words into IMEM (load_valid/load_ready/load_data/load_last),
//           writes appear on imem_we/imem_addr/imem_wdata one cycle after the handshake.
//   ARMED : CPU held in reset, waiting for start.
//   RUN   : CPU released (cpu_reset=0) until cpu_pc==halt_pc or the max_cycles budget.
//   CHECK : walk the expected table via rf_raddr/rf_rdata, one entry per cycle.
//   DONE  : done/pass/timeout/fail_idx/cycles_run held; start re-runs the same program.
//   Table writes: chk_we/chk_idx/chk_en/chk_reg/chk_value (ignored during CHECK).
import cpu_test_pkg::*;

module cpu_test_sequencer #(
    parameter int XLEN       = DEF_XLEN,
    parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter int NUM_CHECKS = DEF_NUM_CHECKS,
    parameter int CYC_W      = DEF_CYC_W,
    localparam int IDX_W     = $clog2(NUM_CHECKS),
    localparam int AW        = $clog2(IMEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    // program load
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [XLEN-1:0]      load_data,
    input  logic                 load_last,
    // run control
    input  logic                 start,
    input  logic [CYC_W-1:0]     max_cycles,
    input  logic [XLEN-1:0]      halt_pc,
    // expected table write
    input  logic                 chk_we,
    input  logic [IDX_W-1:0]     chk_idx,
    input  logic                 chk_en,
    input  logic [REG_IDX_W-1:0] chk_reg,
    input  logic [XLEN-1:0]      chk_value,
    // CPU side
    output logic                 cpu_reset,
    input  logic [XLEN-1:0]      cpu_pc,
    output logic                 imem_we,
    output logic [AW-1:0]        imem_addr,
    output logic [XLEN-1:0]      imem_wdata,
    output logic [REG_IDX_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]      rf_rdata,
    // status
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [IDX_W-1:0]     fail_idx,
    output logic [CYC_W-1:0]     cycles_run
);

    seq_state_t          state;
    logic [AW-1:0]       word_cnt;
    logic [IDX_W-1:0]    chk_ptr;

    logic                tbl_en;
    logic [XLEN-1:0]     tbl_val;
    logic                entry_ok;
    logic                halt_hit;
    logic                budget_hit;
    logic [CYC_W:0]      cyc_inc;

    // Table is frozen while it is being walked so the result is coherent.
    cpu_check_table #(
        .XLEN       (XLEN),
        .NUM_CHECKS (NUM_CHECKS)
    ) u_table (
        .clk  (clk),
        .rst  (reset),
        .we   (chk_we && (state != ST_CHECK)),
        .widx (chk_idx),
        .wen  (chk_en),
        .wreg (chk_reg),
        .wval (chk_value),
        .ridx (chk_ptr),
        .ren  (tbl_en),
        .rreg (rf_raddr),
        .rval (tbl_val)
    );

    assign load_ready = (state == ST_LOAD);
    assign entry_ok   = !tbl_en || (rf_rdata == tbl_val);

    // One extra bit so a saturated counter can never alias onto a budget.
    assign cyc_inc    = {1'b0, cycles_run} + {{CYC_W{1'b0}}, 1'b1};
    assign halt_hit   = (cpu_pc == halt_pc);
    assign budget_hit = (max_cycles != '0) && (cyc_inc == {1'b0, max_cycles});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_LOAD;
            cpu_reset  <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            word_cnt   <= '0;
            chk_ptr    <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            fail_idx   <= '0;
            cycles_run <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (load_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_cnt;
                        imem_wdata <= load_data;
                        word_cnt   <= word_cnt + AW'(1);
                        // Last slot forces ARMED so the address cannot wrap.
                        if (load_last || (word_cnt == '1))
                            state <= ST_ARMED;
                    end
                end
                ST_ARMED, ST_DONE: begin
                    if (start) begin
                        state      <= ST_RUN;
                        cpu_reset  <= 1'b0;
                        cycles_run <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        fail_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    if (halt_hit || budget_hit) begin
                        state     <= ST_CHECK;
                        cpu_reset <= 1'b1;
                        timeout   <= !halt_hit;   // halt wins a tie
                        chk_ptr   <= '0;
                    end else if (cycles_run != '1) begin
                        cycles_run <= cyc_inc[CYC_W-1:0];
                    end
                end
                ST_CHECK: begin
                    if (!entry_ok) begin
                        fail_idx <= chk_ptr;
                        pass     <= 1'b0;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else if (chk_ptr == IDX_W'(NUM_CHECKS - 1)) begin
                        pass  <= !timeout;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        chk_ptr <= chk_ptr + IDX_W'(1);
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_test_sequencer.sv
module tb_cpu_test_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid, load_ready, load_last;
    logic [31:0] load_data;
    logic        start;
    logic [15:0] max_cycles;
    logic [31:0] halt_pc;
    logic        chk_we, chk_en;
    logic [2:0]  chk_idx;
    logic [4:0]  chk_reg;
    logic [31:0] chk_value;
    logic        cpu_reset;
    logic [31:0] cpu_pc = '0;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        done, pass, timeout;
    logic [2:0]  fail_idx;
    logic [15:0] cycles_run;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          at;
    } wr_t;

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [2:0]  fidx;
        logic [15:0] cycles;
        string       name;
    } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];
    int   next_addr;

    cpu_test_sequencer dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .start(start), .max_cycles(max_cycles), .halt_pc(halt_pc),
        .chk_we(chk_we), .chk_idx(chk_idx), .chk_en(chk_en),
        .chk_reg(chk_reg), .chk_value(chk_value),
        .cpu_reset(cpu_reset), .cpu_pc(cpu_pc),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .done(done), .pass(pass), .timeout(timeout),
        .fail_idx(fail_idx), .cycles_run(cycles_run)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Toy CPU: PC steps by 4 while released; ADD x3,x1,x2 at PC 0, ADD x4,x3,x1 at PC 4.
    logic [31:0] x3 = '0;
    logic [31:0] x4 = '0;
    always @(posedge clk) begin
        if (cpu_reset) cpu_pc <= '0;
        else begin
            if (cpu_pc == 32'h0) x3 <= 32'd1 + 32'd2;
            if (cpu_pc == 32'h4) x4 <= x3 + 32'd1;
            cpu_pc <= cpu_pc + 32'd4;
        end
    end
    assign rf_rdata = (rf_raddr == 5'd1) ? 32'd1 :
                      (rf_raddr == 5'd2) ? 32'd2 :
                      (rf_raddr == 5'd3) ? x3 :
                      (rf_raddr == 5'd4) ? x4 : 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes IMEM or raises done.
    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_q.size() == 0) check("imem_unexpected_write", 64'(imem_addr), 64'hFFFF);
            else begin
                wr_t e;
                e = wr_q.pop_front();
                check("imem_addr", 64'(imem_addr), 64'(e.addr));
                check("imem_wdata", 64'(imem_wdata), 64'(e.data));
                check("imem_lag", 64'(cyc), 64'(e.at));
            end
        end
        if (done && !done_q) begin
            if (res_q.size() == 0) check("unexpected_done", 64'(done), 64'd0);
            else begin
                res_t r;
                r = res_q.pop_front();
                check({r.name, "_pass"},       64'(pass),       64'(r.pass));
                check({r.name, "_timeout"},    64'(timeout),    64'(r.timeout));
                check({r.name, "_fail_idx"},   64'(fail_idx),   64'(r.fidx));
                check({r.name, "_cycles_run"}, 64'(cycles_run), 64'(r.cycles));
            end
        end
        done_q <= done;
    end

    task automatic send(input logic [31:0] d, input logic last, input int stall);
        repeat (stall) begin @(negedge clk); load_valid = 1'b0; end
        @(negedge clk);
        check("load_ready_in_load", 64'(load_ready), 64'd1);
        load_valid = 1'b1; load_data = d; load_last = last;
        wr_q.push_back('{addr: 6'(next_addr), data: d, at: cyc + 1});
        next_addr++;
    endtask

    task automatic end_load();
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic wr_chk(input int idx, input logic en, input logic [4:0] r, input logic [31:0] v);
        @(negedge clk);
        chk_we = 1'b1; chk_idx = 3'(idx); chk_en = en; chk_reg = r; chk_value = v;
        @(negedge clk);
        chk_we = 1'b0;
    endtask

    task automatic run(input string nm, input logic ep, input logic et,
                       input logic [2:0] ef, input logic [15:0] ec);
        res_q.push_back('{pass: ep, timeout: et, fidx: ef, cycles: ec, name: nm});
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({nm, "_cpu_released"}, 64'(cpu_reset), 64'd0);
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        check({nm, "_done_reached"}, 64'(done), 64'd1);
        @(negedge clk);
        check({nm, "_cpu_held"}, 64'(cpu_reset), 64'd1);
    endtask

    initial begin
        reset = 1'b1; load_valid = 0; load_last = 0; load_data = '0; start = 0;
        max_cycles = '0; halt_pc = 32'h10; chk_we = 0; chk_idx = '0; chk_en = 0;
        chk_reg = '0; chk_value = '0; next_addr = 0;
        repeat (2) @(negedge clk);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        check("rst_imem_we", 64'(imem_we), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'd0);
        check("rst_status", 64'({done, pass, timeout, fail_idx}), 64'd0);
        check("rst_cycles_run", 64'(cycles_run), 64'd0);
        reset = 1'b0;

        // start while loading is ignored
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_in_load_ignored", 64'(cpu_reset), 64'd1);
        check("still_in_load", 64'(load_ready), 64'd1);

        // 6-word program, last on word 5
        send(32'h002081B3, 1'b0, 0);   // ADD x3,x1,x2
        send(32'h00118233, 1'b0, 1);   // ADD x4,x3,x1
        send(32'h00000013, 1'b0, 0);   // NOP
        send(32'h00000013, 1'b0, 2);
        send(32'h00000013, 1'b0, 0);
        send(32'h0000006F, 1'b1, 1);   // J .
        end_load();
        check("armed_load_ready", 64'(load_ready), 64'd0);
        check("armed_cpu_reset", 64'(cpu_reset), 64'd1);
        // load_valid outside LOAD must not write
        load_valid = 1'b1;
        @(negedge clk);
        check("no_write_when_armed", 64'(imem_we), 64'd0);
        load_valid = 1'b0;

        wr_chk(0, 1'b1, 5'd3, 32'd3);
        wr_chk(1, 1'b1, 5'd4, 32'd4);
        halt_pc = 32'h10; max_cycles = '0;
        run("halt_pass", 1'b1, 1'b0, 3'd0, 16'd4);

        wr_chk(1, 1'b1, 5'd4, 32'd5);
        run("mismatch", 1'b0, 1'b0, 3'd1, 16'd4);

        wr_chk(1, 1'b1, 5'd4, 32'd4);
        halt_pc = 32'hFFFF_FFF0; max_cycles = 16'd20;
        run("budget", 1'b0, 1'b1, 3'd0, 16'd19);

        halt_pc = 32'h10; max_cycles = 16'd5;
        run("tie_halt_wins", 1'b1, 1'b0, 3'd0, 16'd4);

        // reset in the middle of a run
        halt_pc = 32'hFFFF_FFF0; max_cycles = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrun_cpu_reset_async", 64'(cpu_reset), 64'd1);
        check("midrun_back_to_load", 64'(load_ready), 64'd1);
        check("midrun_done_low", 64'(done), 64'd0);
        @(negedge clk); reset = 1'b0;

        // 64 words, random stalls, no load_last: auto-arm after addr 63
        next_addr = 0;
        for (int i = 0; i < 64; i++) send(32'hA000_0000 + 32'(i), 1'b0, int'($urandom_range(0, 2)));
        end_load();
        check("full_auto_armed", 64'(load_ready), 64'd0);

        wr_chk(0, 1'b1, 5'd3, 32'd3);
        wr_chk(5, 1'b1, 5'd4, 32'd4);
        halt_pc = 32'h10; max_cycles = '0;
        run("after_reset", 1'b1, 1'b0, 3'd0, 16'd4);
        run("rerun_from_done", 1'b1, 1'b0, 3'd0, 16'd4);

        repeat (3) @(negedge clk);
        check("imem_queue_drained", 64'(wr_q.size()), 64'd0);
        check("result_queue_drained", 64'(res_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
